// File: rtl/id_ex_register_pkg.sv
// rtl/id_ex_register_pkg.sv - ID/EX control-word layout, instruction fields and opcodes
package id_ex_register_pkg;

    localparam int CTRL_W    = 9;
    localparam int EX_W      = 4;
    localparam int MEM_W     = 3;
    localparam int WB_W      = 2;

    localparam int EX_MSB    = 8;
    localparam int EX_LSB    = 5;
    localparam int MEM_MSB   = 4;
    localparam int MEM_LSB   = 2;
    localparam int WB_MSB    = 1;
    localparam int WB_LSB    = 0;

    // MEM field is {Branch, MemRead, MemWrite}
    localparam int MEM_READ_BIT = 1;

    localparam int INSTR_W   = 32;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SPEC_W    = 5;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;

    function automatic logic [SPEC_W-1:0] instr_rs(input logic [INSTR_W-1:0] instr);
        return instr[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [SPEC_W-1:0] instr_rt(input logic [INSTR_W-1:0] instr);
        return instr[RT_MSB:RT_LSB];
    endfunction

    function automatic logic [SPEC_W-1:0] instr_rd(input logic [INSTR_W-1:0] instr);
        return instr[RD_MSB:RD_LSB];
    endfunction

endpackage

// File: rtl/id_ex_register_if.sv
// rtl/id_ex_register_if.sv - ID-side inputs and EX-side outputs of the ID/EX register
interface id_ex_register_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic [8:0]        inControl;
    logic [31:0]       inInstruction;
    logic [DATA_W-1:0] inPC4;
    logic [DATA_W-1:0] inReadData1;
    logic [DATA_W-1:0] inReadData2;
    logic [DATA_W-1:0] inSignExt;
    logic              inFlush;
    logic              inHalt;

    logic [3:0]        outEX;
    logic [2:0]        outMEM;
    logic [1:0]        outWB;
    logic [DATA_W-1:0] outPC4;
    logic [DATA_W-1:0] outReadData1;
    logic [DATA_W-1:0] outReadData2;
    logic [DATA_W-1:0] outSignExt;
    logic [REG_W-1:0]  outRs;
    logic [REG_W-1:0]  outRt;
    logic [REG_W-1:0]  outRd;
    logic              outStall;

    modport master (
        output inControl, inInstruction, inPC4, inReadData1, inReadData2, inSignExt,
               inFlush, inHalt,
        input  outEX, outMEM, outWB, outPC4, outReadData1, outReadData2, outSignExt,
               outRs, outRt, outRd, outStall
    );

    modport slave (
        input  inControl, inInstruction, inPC4, inReadData1, inReadData2, inSignExt,
               inFlush, inHalt,
        output outEX, outMEM, outWB, outPC4, outReadData1, outReadData2, outSignExt,
               outRs, outRt, outRd, outStall
    );
endinterface

// File: rtl/id_ex_register_load_use_detector.sv
// rtl/id_ex_register_load_use_detector.sv - combinational load-use compare against the EX-stage load
module load_use_detector #(
    parameter int REG_W = 5
) (
    input  logic             mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    output logic             hazard_o
);
    // $0 is hardwired, so a load targeting it never creates a dependency
    assign hazard_o = mem_read_i
                    & (ex_rt_i != '0)
                    & ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
endmodule

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with load-use bubble and flush squash
// Build option: LOAD_USE_HAZARD_EN enables the load-use detector and stall output.
module id_ex_register
    import id_ex_register_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    id_ex_register_if.slave  bus
);
    logic [EX_W-1:0]   ex_q,   ex_d;
    logic [MEM_W-1:0]  mem_q,  mem_d;
    logic [WB_W-1:0]   wb_q,   wb_d;
    logic [DATA_W-1:0] pc4_q,  pc4_d;
    logic [DATA_W-1:0] rd1_q,  rd1_d;
    logic [DATA_W-1:0] rd2_q,  rd2_d;
    logic [DATA_W-1:0] sx_q,   sx_d;
    logic [REG_W-1:0]  rs_q,   rs_d;
    logic [REG_W-1:0]  rt_q,   rt_d;
    logic [REG_W-1:0]  rd_q,   rd_d;

    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic [REG_W-1:0]  id_rd;
    logic              hazard;

    assign id_rs = REG_W'(instr_rs(bus.inInstruction));
    assign id_rt = REG_W'(instr_rt(bus.inInstruction));
    assign id_rd = REG_W'(instr_rd(bus.inInstruction));

`ifdef LOAD_USE_HAZARD_EN
    load_use_detector #(
        .REG_W (REG_W)
    ) u_load_use_detector (
        .mem_read_i (mem_q[MEM_READ_BIT]),
        .ex_rt_i    (rt_q),
        .id_rs_i    (id_rs),
        .id_rt_i    (id_rt),
        .hazard_o   (hazard)
    );
`else
    assign hazard = 1'b0;
`endif

    // A flush already squashes the stage, so the front end need not hold
    assign bus.outStall = hazard & ~bus.inFlush;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        pc4_d = pc4_q;
        rd1_d = rd1_q;
        rd2_d = rd2_q;
        sx_d  = sx_q;
        rs_d  = rs_q;
        rt_d  = rt_q;
        rd_d  = rd_q;
        if (!bus.inHalt) begin
            pc4_d = bus.inPC4;
            rd1_d = bus.inReadData1;
            rd2_d = bus.inReadData2;
            sx_d  = bus.inSignExt;
            rs_d  = id_rs;
            rt_d  = id_rt;
            rd_d  = id_rd;
            if (bus.inFlush || hazard) begin
                ex_d  = '0;
                mem_d = '0;
                wb_d  = '0;
            end else begin
                ex_d  = bus.inControl[EX_MSB:EX_LSB];
                mem_d = bus.inControl[MEM_MSB:MEM_LSB];
                wb_d  = bus.inControl[WB_MSB:WB_LSB];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            pc4_q <= '0;
            rd1_q <= '0;
            rd2_q <= '0;
            sx_q  <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            rd_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            pc4_q <= pc4_d;
            rd1_q <= rd1_d;
            rd2_q <= rd2_d;
            sx_q  <= sx_d;
            rs_q  <= rs_d;
            rt_q  <= rt_d;
            rd_q  <= rd_d;
        end
    end

    assign bus.outEX        = ex_q;
    assign bus.outMEM       = mem_q;
    assign bus.outWB        = wb_q;
    assign bus.outPC4       = pc4_q;
    assign bus.outReadData1 = rd1_q;
    assign bus.outReadData2 = rd2_q;
    assign bus.outSignExt   = sx_q;
    assign bus.outRs        = rs_q;
    assign bus.outRt        = rt_q;
    assign bus.outRd        = rd_q;
endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - scoreboard bench for id_ex_register
module tb_id_ex_register;

`ifdef LOAD_USE_HAZARD_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    localparam logic [8:0] C_R  = 9'b1100_000_10;
    localparam logic [8:0] C_LW = 9'b0001_010_11;

    typedef struct packed {
        logic        rst;
        logic        halt;
        logic        flush;
        logic [8:0]  ctrl;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sx;
    } vec_t;

    typedef struct packed {
        int          id;
        logic [8:0]  ctrl;
        logic [31:0] pc4;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sx;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        stall;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_register_if #(.DATA_W(32), .REG_W(5)) bus ();

    id_ex_register #(.DATA_W(32), .REG_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'd0, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic vec_t mk(input logic r, input logic h, input logic f, input logic [8:0] c,
                                input logic [31:0] ins, input logic [31:0] pc4, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] sx);
        vec_t v;
        v.rst = r; v.halt = h; v.flush = f; v.ctrl = c; v.instr = ins;
        v.pc4 = pc4; v.rd1 = d1; v.rd2 = d2; v.sx = sx;
        return v;
    endfunction

    function automatic exp_t ex_of(input vec_t lat, input logic [8:0] c, input logic st);
        exp_t e;
        e.id = 0; e.ctrl = c; e.pc4 = lat.pc4; e.rd1 = lat.rd1; e.rd2 = lat.rd2; e.sx = lat.sx;
        e.rs = lat.instr[25:21]; e.rt = lat.instr[20:16]; e.rd = lat.instr[15:11]; e.stall = st;
        return e;
    endfunction

    task automatic drive(input vec_t v);
        rst               = v.rst;
        bus.inHalt        = v.halt;
        bus.inFlush       = v.flush;
        bus.inControl     = v.ctrl;
        bus.inInstruction = v.instr;
        bus.inPC4         = v.pc4;
        bus.inReadData1   = v.rd1;
        bus.inReadData2   = v.rd2;
        bus.inSignExt     = v.sx;
    endtask

    // After each edge: apply this cycle's inputs and queue the expected state/stall
    task automatic step(input vec_t v, input exp_t e);
        @(posedge clk);
        #1;
        drive(v);
        step_no++;
        e.id = step_no;
        sb.push_back(e);
    endtask

    task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", id, name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.id, "outEX",        32'(bus.outEX),        32'(e.ctrl[8:5]));
                chk(e.id, "outMEM",       32'(bus.outMEM),       32'(e.ctrl[4:2]));
                chk(e.id, "outWB",        32'(bus.outWB),        32'(e.ctrl[1:0]));
                chk(e.id, "outPC4",       bus.outPC4,            e.pc4);
                chk(e.id, "outReadData1", bus.outReadData1,      e.rd1);
                chk(e.id, "outReadData2", bus.outReadData2,      e.rd2);
                chk(e.id, "outSignExt",   bus.outSignExt,        e.sx);
                chk(e.id, "outRs",        32'(bus.outRs),        32'(e.rs));
                chk(e.id, "outRt",        32'(bus.outRt),        32'(e.rt));
                chk(e.id, "outRd",        32'(bus.outRd),        32'(e.rd));
                chk(e.id, "outStall",     32'(bus.outStall),     32'(e.stall));
            end
        end
    end

    initial begin : stimulus
        vec_t z, a, r, lw, add, lw0, use0, add67, usert, addh, xh, yh, add_rst;
        z       = '0;
        a       = mk(0, 0, 0, 9'h1FF, rtype(9, 10, 11), 32'hDEAD0, 32'hAAAA, 32'hBBBB, 32'hCCCC);
        r       = mk(1, 0, 0, C_R,  rtype(1, 2, 3),           32'h104, 32'h11, 32'h22, 32'h0);
        lw      = mk(1, 0, 0, C_LW, itype(6'd35, 1, 5, 16'h8), 32'h108, 32'h33, 32'h44, 32'h8);
        add     = mk(1, 0, 0, C_R,  rtype(5, 6, 7),           32'h10C, 32'h55, 32'h66, 32'h0);
        lw0     = mk(1, 0, 0, C_LW, itype(6'd35, 2, 0, 16'h4), 32'h110, 32'h77, 32'h88, 32'h4);
        use0    = mk(1, 0, 0, C_R,  rtype(0, 0, 8),           32'h114, 32'h0,  32'h0,  32'h0);
        add67   = mk(1, 0, 0, C_R,  rtype(6, 7, 9),           32'h118, 32'h99, 32'hAA, 32'h0);
        usert   = mk(1, 0, 1, C_R,  rtype(3, 5, 10),          32'h11C, 32'hBB, 32'hCC, 32'h0);
        addh    = add;  addh.halt = 1'b1;
        xh      = mk(1, 1, 0, C_R,  rtype(5, 4, 12),          32'h120, 32'hDD, 32'hEE, 32'h0);
        yh      = mk(1, 1, 0, C_R,  rtype(1, 2, 13),          32'h124, 32'hF1, 32'hF2, 32'h0);
        add_rst = add;  add_rst.rst = 1'b0;

        drive(a);
        step(a,       ex_of(z, 9'd0, 1'b0));
        step(r,       ex_of(z, 9'd0, 1'b0));
        step(lw,      ex_of(r, C_R, 1'b0));
        step(add,     ex_of(lw, C_LW, HZ));
        step(add,     HZ ? ex_of(add, 9'd0, 1'b0) : ex_of(add, C_R, 1'b0));
        step(lw0,     ex_of(add, C_R, 1'b0));
        step(use0,    ex_of(lw0, C_LW, 1'b0));
        step(lw,      ex_of(use0, C_R, 1'b0));
        step(add67,   ex_of(lw, C_LW, 1'b0));
        step(lw,      ex_of(add67, C_R, 1'b0));
        step(usert,   ex_of(lw, C_LW, 1'b0));
        step(lw,      ex_of(usert, 9'd0, 1'b0));
        step(addh,    ex_of(lw, C_LW, HZ));
        step(xh,      ex_of(lw, C_LW, HZ));
        step(yh,      ex_of(lw, C_LW, 1'b0));
        step(add,     ex_of(lw, C_LW, HZ));
        step(r,       HZ ? ex_of(add, 9'd0, 1'b0) : ex_of(add, C_R, 1'b0));
        step(lw,      ex_of(r, C_R, 1'b0));
        step(add_rst, ex_of(lw, C_LW, HZ));
        step(r,       ex_of(z, 9'd0, 1'b0));
        step(r,       ex_of(r, C_R, 1'b0));

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
